// File: rtl/lz4_fwft_fifo.sv
// First-word-fall-through synchronous FIFO with count-derived status flags.
// Define LZ4_FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module lz4_fwft_fifo #(
   parameter int DATA_W    = 47,
   parameter int ADDR_W    = 6,
   parameter int AF_THRESH = 60,
   parameter int AE_THRESH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   data_count
`ifdef LZ4_FIFO_ERR_FLAG_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              wa;
   logic              ra;

   always_comb begin
      empty        = (count == '0);
      full         = (count == DEPTH_C);
      almost_empty = (count <= AE_C);
      almost_full  = (count >= AF_C);
      data_count   = count;
      wa           = wr_en & ~full;
      ra           = rd_en & ~empty;
      valid        = ra;
      // Asynchronous-read head; forced to zero while empty so reset shows dout=0
      // without clearing the array.
      dout         = empty ? '0 : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (wa) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wa) wr_ptr <= wr_ptr + 1'b1;
         if (ra) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wa, ra})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef LZ4_FIFO_ERR_FLAG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & full)  overflow  <= 1'b1;
         if (rd_en & empty) underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/lz4_fwft_fifo.md
# lz4_fwft_fifo

Parametrised first-word-fall-through synchronous FIFO for the LZ4/Huffman compression datapath: the native-RTL successor of the fixed 64-deep, 47-bit BRAM-core-wrapped token FIFO. Width, depth and almost-full/almost-empty thresholds are set by parameters. It adds a qualified read acknowledge and threshold flags for back-pressure between the match finder, the sequence encoder and the Huffman stage. It optionally adds sticky overflow/underflow error flags.

## Interface
- DATA_W, 47, word width in bits (1..256)
- ADDR_W, 6, log2 of depth; DEPTH = 2**ADDR_W (2..4096 words)
- AF_THRESH, 60, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  DATA_W  write data
- wr_en  in  1  write request
- rd_en  in  1  read (pop) request
- dout  out  DATA_W  oldest stored word; meaningful only while empty=0
- valid  out  1  read acknowledge: rd_en & ~empty (combinational)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_THRESH
- almost_full  out  1  count >= AF_THRESH
- data_count  out  ADDR_W+1  number of stored words, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags (only with LZ4_FIFO_ERR_FLAG_EN)

## Operation
- Storage: DEPTH-entry array, write pointer and read pointer of ADDR_W bits each, and a registered count of ADDR_W+1 bits.
- Pointers wrap modulo DEPTH naturally. Full and empty come from the count, never from pointer compare.
- Write accepted (wa) iff wr_en & ~full, evaluated on pre-edge flags. The write stores din at wr_ptr and increments wr_ptr.
- Read accepted (ra) iff rd_en & ~empty. A read increments rd_ptr, and dout advances to the next word.
- Count update: +1 on wa&~ra, -1 on ra&~wa, unchanged on both or neither.
- Full with wr_en&rd_en: the read is accepted and the write is dropped. Count goes to DEPTH-1, and full deasserts next cycle.
- Empty with wr_en&rd_en: the write is accepted and the read is ignored (valid=0). Count goes to 1.
- FWFT: dout always presents mem[rd_ptr]. No rd_en is needed to see the head word.
  - Implement either with an asynchronous-read array or with a prefetch output register. Observable behaviour must be identical.
- Dropped write (wr_en while full without the read case above, or any wr_en while full): memory and pointers are unchanged.
- Dropped read (rd_en while empty): pointers are unchanged, and dout is don't-care.
- Flags almost_*, empty, full and data_count are decoded from the count register, so they change only on clock edges or on reset.

## Timing
- Reset values: data_count=0, empty=1, full=0, almost_empty=1, almost_full = (AF_THRESH==0 ? 1 : 0) (effectively 0 within the legal range), dout=0, overflow=underflow=0, pointers=0.
- Reset takes effect immediately and asynchronously. Reset mid-operation discards all contents; there is no partial-state retention.
- Write-to-dout latency is 1 cycle: a word written at edge N into an empty FIFO is on dout with empty=0 after edge N.
- Read-to-next-word latency is 0 extra cycles: after a pop at edge N, the next word is on dout after edge N.
- Full deasserts 1 cycle after the first accepted read. Empty asserts after the edge that pops the last word.
- Throughput: one write and one read per cycle sustained.

## Configuration
- LZ4_FIFO_ERR_FLAG_EN defined:
  - Ports overflow and underflow exist.
  - overflow sets on any edge with wr_en & full; underflow sets on any edge with rd_en & empty.
  - Both hold until rst.
- Not defined: both ports and their logic are absent. Dropped accesses are silent.

## Test plan
- Reset then idle (DATA_W=47, ADDR_W=6) -> empty=1, full=0, data_count=0, almost_empty=1, dout=0, valid=0.
- Write 0x1 at edge N, no read -> after N: dout=0x1, empty=0, data_count=1. Hold rd_en=1 one cycle -> valid=1, empty=1, data_count=0.
- Write 64 words 0..63 -> almost_full rises after word 60 (count=60), full=1 at count=64. A 65th write is dropped. Read back 0..63 in order with pointers wrapping.
- Full, wr_en=rd_en=1 with din=0xAA -> dout advances to word 1, data_count=63, 0xAA never appears. Empty, wr_en=rd_en=1 with din=0x55 -> valid=0, data_count=1, dout=0x55.
- Interleaved random read/write, 10k cycles, with a wrap past pointer 63 -> data order matches the scoreboard, and data_count always equals writes minus reads.
- With LZ4_FIFO_ERR_FLAG_EN: wr_en while full -> overflow=1 and it stays high. rd_en while empty -> underflow=1. Assert rst mid-burst -> both 0 immediately, count=0.
